// File: rtl/commit_retire.sv
// In-order retirement stage: pops the finished prefix at the ROB head and
// walks the ROB on a head exception. Optional macro: COMMIT_RETIRE_COUNTER_EN.
package commit_retire_pkg;
   localparam int PHY_W = 6;

   typedef enum logic [3:0] {
      EXC_INSN_MISALIGN  = 4'd0,
      EXC_INSN_FAULT     = 4'd1,
      EXC_ILLEGAL        = 4'd2,
      EXC_BREAKPOINT     = 4'd3,
      EXC_LOAD_MISALIGN  = 4'd4,
      EXC_LOAD_FAULT     = 4'd5,
      EXC_STORE_MISALIGN = 4'd6,
      EXC_STORE_FAULT    = 4'd7,
      EXC_ECALL_U        = 4'd8,
      EXC_ECALL_S        = 4'd9,
      EXC_RSVD_10        = 4'd10,
      EXC_ECALL_M        = 4'd11
   } riscv_exception_t;

   typedef struct packed {
      logic             finish;
      logic             has_exception;
      riscv_exception_t exception_id;
      logic [31:0]      pc;
      logic [31:0]      exception_value;
      logic [PHY_W-1:0] new_phy_reg_id;
      logic [PHY_W-1:0] old_phy_reg_id;
      logic             old_phy_reg_id_valid;
   } rob_item_t;
endpackage

module commit_retire
   import commit_retire_pkg::*;
#(
   parameter int COMMIT_WIDTH     = 4,
   parameter int ROB_ID_WIDTH     = 5,
   parameter int PHY_REG_ID_WIDTH = PHY_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ROB_ID_WIDTH-1:0]     rob_commit_retire_head_id,
   input  logic                        rob_commit_retire_head_id_valid,
   output logic [COMMIT_WIDTH-1:0][ROB_ID_WIDTH-1:0] commit_rob_retire_id,
   input  rob_item_t [COMMIT_WIDTH-1:0] rob_commit_retire_data,
   input  logic [COMMIT_WIDTH-1:0]     rob_commit_retire_id_valid,
   output logic [COMMIT_WIDTH-1:0]     commit_rob_retire_pop,
   input  logic [ROB_ID_WIDTH-1:0]     rob_commit_flush_tail_id,
   input  logic                        rob_commit_flush_tail_id_valid,
   output logic [ROB_ID_WIDTH-1:0]     commit_rob_flush_id,
   input  rob_item_t                   rob_commit_flush_data,
   input  logic [ROB_ID_WIDTH-1:0]     rob_commit_flush_next_id,
   input  logic                        rob_commit_flush_next_id_valid,
   output logic                        commit_rob_flush,
   output logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] commit_phy_release_id,
   output logic [COMMIT_WIDTH-1:0]     commit_phy_release_valid,
   output logic [PHY_REG_ID_WIDTH-1:0] commit_rat_restore_new_id,
   output logic [PHY_REG_ID_WIDTH-1:0] commit_rat_restore_old_id,
   output logic                        commit_rat_restore_valid,
   output logic                        commit_exception_valid,
   output logic [31:0]                 commit_exception_pc,
   output riscv_exception_t            commit_exception_id,
   output logic [31:0]                 commit_exception_value,
   output logic [63:0]                 commit_retired_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WALK  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ROB_ID_WIDTH-1:0] flush_id_q, flush_id_d;
   logic [31:0]             exc_pc_q, exc_pc_d;
   logic [31:0]             exc_val_q, exc_val_d;
   riscv_exception_t        exc_id_q, exc_id_d;
   logic [COMMIT_WIDTH-1:0] pop;
   logic [COMMIT_WIDTH-1:0] rel_v_q, rel_v_d;
   logic [COMMIT_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] rel_id_q, rel_id_d;
   logic                    head_exc;
   logic                    unused_bits;

   // Unread struct fields (pc of younger slots etc.) are sunk here.
   assign unused_bits = ^{rob_commit_retire_data, rob_commit_flush_data};

   // Finished, exception-free prefix starting at the head slot.
   always_comb begin
      logic run;
      pop = '0;
      run = (state_q == IDLE) && rob_commit_retire_head_id_valid;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         run = run
             & rob_commit_retire_id_valid[i]
             & rob_commit_retire_data[i].finish
             & ~rob_commit_retire_data[i].has_exception;
         pop[i] = run;
      end
   end

   assign head_exc = (state_q == IDLE)
                   & rob_commit_retire_head_id_valid
                   & rob_commit_flush_tail_id_valid
                   & rob_commit_retire_id_valid[0]
                   & rob_commit_retire_data[0].finish
                   & rob_commit_retire_data[0].has_exception;

   // Next state: enter the walk from the tail on a head trap.
   always_comb begin
      state_d    = state_q;
      flush_id_d = flush_id_q;
      exc_pc_d   = exc_pc_q;
      exc_val_d  = exc_val_q;
      exc_id_d   = exc_id_q;
      unique case (state_q)
         IDLE: begin
            if (head_exc) begin
               state_d    = WALK;
               flush_id_d = rob_commit_flush_tail_id;
               exc_pc_d   = rob_commit_retire_data[0].pc;
               exc_val_d  = rob_commit_retire_data[0].exception_value;
               exc_id_d   = rob_commit_retire_data[0].exception_id;
            end
         end
         WALK: begin
            if (rob_commit_flush_next_id_valid) begin
               flush_id_d = rob_commit_flush_next_id;
            end else begin
               state_d = FLUSH;
            end
         end
         FLUSH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Free-list release candidates for the next cycle.
   always_comb begin
      rel_v_d  = '0;
      rel_id_d = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         rel_v_d[i] = pop[i]
                    & rob_commit_retire_data[i].old_phy_reg_id_valid;
         if (state_q == IDLE) begin
            rel_id_d[i] = rob_commit_retire_data[i].old_phy_reg_id;
         end
      end
   end

   // State, walk pointer, latched trap fields and release registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         flush_id_q <= '0;
         exc_pc_q   <= '0;
         exc_val_q  <= '0;
         exc_id_q   <= EXC_INSN_MISALIGN;
         rel_v_q    <= '0;
         rel_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         flush_id_q <= flush_id_d;
         exc_pc_q   <= exc_pc_d;
         exc_val_q  <= exc_val_d;
         exc_id_q   <= exc_id_d;
         rel_v_q    <= rel_v_d;
         rel_id_q   <= rel_id_d;
      end
   end

   // Slot ids wrap modulo the ROB size; held at zero while in reset.
   always_comb begin
      commit_rob_retire_id = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (rst) begin
            commit_rob_retire_id[i] =
               rob_commit_retire_head_id + ROB_ID_WIDTH'(i);
         end
      end
   end

   assign commit_rob_retire_pop = rst ? pop : '0;
   assign commit_rob_flush_id   = flush_id_q;
   assign commit_rob_flush      = (state_q == FLUSH);
   assign commit_exception_valid = (state_q == FLUSH);
   assign commit_exception_pc    = exc_pc_q;
   assign commit_exception_id    = exc_id_q;
   assign commit_exception_value = exc_val_q;

   assign commit_rat_restore_valid = (state_q == WALK)
      & rob_commit_flush_data.old_phy_reg_id_valid;
   assign commit_rat_restore_new_id = (state_q == WALK)
      ? rob_commit_flush_data.new_phy_reg_id : '0;
   assign commit_rat_restore_old_id = (state_q == WALK)
      ? rob_commit_flush_data.old_phy_reg_id : '0;

   assign commit_phy_release_valid = (state_q == IDLE) ? rel_v_q : '0;
   assign commit_phy_release_id    = (state_q == IDLE) ? rel_id_q : '0;

`ifdef COMMIT_RETIRE_COUNTER_EN
   logic [63:0] count_q, count_d;

   // Add the number of entries popped this cycle.
   always_comb begin
      count_d = count_q;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         count_d = count_d + 64'(pop[i]);
      end
   end

   // Retired-instruction counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign commit_retired_count = count_q;
`else
   assign commit_retired_count = '0;
`endif

endmodule

// File: tb/tb_commit_retire.sv
// Scoreboard bench for commit_retire: a queue-based ROB model predicts
// pops, releases, the rename walk and the trap pulse cycle by cycle.
`timescale 1ns/1ps
module tb_commit_retire;
   import commit_retire_pkg::*;

   localparam int CW  = 4;
   localparam int RW  = 5;
   localparam int PW  = 6;
   localparam int RSZ = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [RW-1:0]          hid;
   logic                   hv;
   logic [CW-1:0][RW-1:0]  rid;
   rob_item_t [CW-1:0]     rdata;
   logic [CW-1:0]          idv;
   logic [CW-1:0]          pop;
   logic [RW-1:0]          tail;
   logic                   tail_v;
   logic [RW-1:0]          fid;
   rob_item_t              fdata;
   logic [RW-1:0]          fnext;
   logic                   fnext_v;
   logic                   rflush;
   logic [CW-1:0][PW-1:0]  rel_id;
   logic [CW-1:0]          rel_v;
   logic [PW-1:0]          rs_new, rs_old;
   logic                   rs_v;
   logic                   exc_v;
   logic [31:0]            exc_pc, exc_val;
   riscv_exception_t       exc_id;
   logic [63:0]            rcount;

   commit_retire dut (
      .clk                             (clk),
      .rst                             (rst),
      .rob_commit_retire_head_id       (hid),
      .rob_commit_retire_head_id_valid (hv),
      .commit_rob_retire_id            (rid),
      .rob_commit_retire_data          (rdata),
      .rob_commit_retire_id_valid      (idv),
      .commit_rob_retire_pop           (pop),
      .rob_commit_flush_tail_id        (tail),
      .rob_commit_flush_tail_id_valid  (tail_v),
      .commit_rob_flush_id             (fid),
      .rob_commit_flush_data           (fdata),
      .rob_commit_flush_next_id        (fnext),
      .rob_commit_flush_next_id_valid  (fnext_v),
      .commit_rob_flush                (rflush),
      .commit_phy_release_id           (rel_id),
      .commit_phy_release_valid        (rel_v),
      .commit_rat_restore_new_id       (rs_new),
      .commit_rat_restore_old_id       (rs_old),
      .commit_rat_restore_valid        (rs_v),
      .commit_exception_valid          (exc_v),
      .commit_exception_pc             (exc_pc),
      .commit_exception_id             (exc_id),
      .commit_exception_value          (exc_val),
      .commit_retired_count            (rcount)
   );

   typedef struct packed {
      logic [CW-1:0]         pop;
      logic [CW-1:0][RW-1:0] rid;
      logic [CW-1:0]         rv;
      logic [CW-1:0][PW-1:0] rel;
      logic                  walk;
      logic [RW-1:0]         fid;
      logic                  rs_v;
      logic [PW-1:0]         rs_new;
      logic [PW-1:0]         rs_old;
      logic                  fl;
      logic [31:0]           pc;
      logic [31:0]           val;
      logic [3:0]            eid;
      logic [63:0]           cnt;
   } exp_t;

   rob_item_t             rob_mem [RSZ];
   logic [RW-1:0]         head;
   int                    cnt;
   logic [63:0]           total;
   logic [CW-1:0]         prv;
   logic [CW-1:0][PW-1:0] prid;
   bit                    rand_en;
   exp_t                  expq [$];
   exp_t                  pend [$];
   int                    n_chk;
   int                    n_fail;

   // ROB side of the walk: entry at the pointer, next-older id.
   always_comb begin
      fdata   = rob_mem[fid];
      fnext   = fid - 1'b1;
      fnext_v = (fid != hid);
   end

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] idx(input int k);
      return head + RW'(k);
   endfunction

   function automatic rob_item_t rnd_item();
      rob_item_t e;
      e.finish               = ($urandom_range(0, 99) < 50);
      e.has_exception        = ($urandom_range(0, 99) < 4);
      e.exception_id         = riscv_exception_t'($urandom_range(0, 11));
      e.pc                   = $urandom;
      e.exception_value      = $urandom;
      e.new_phy_reg_id       = PW'($urandom);
      e.old_phy_reg_id       = PW'($urandom);
      e.old_phy_reg_id_valid = 1'($urandom_range(0, 1));
      return e;
   endfunction

   function automatic exp_t base();
      exp_t b;
      b = '0;
      for (int i = 0; i < CW; i++) b.rid[i] = idx(i);
`ifdef COMMIT_RETIRE_COUNTER_EN
      b.cnt = total;
`endif
      return b;
   endfunction

   task automatic drive();
      hid    = head;
      hv     = (cnt != 0);
      tail   = head + RW'(cnt - 1);
      tail_v = (cnt != 0);
      for (int i = 0; i < CW; i++) begin
         rdata[i] = rob_mem[idx(i)];
         idv[i]   = (i < cnt);
      end
   endtask

   task automatic load(input logic [RW-1:0] h, input int n);
      rob_item_t e;
      head = h;
      cnt  = n;
      for (int i = 0; i < n; i++) begin
         e = rnd_item();
         e.finish               = 1'b1;
         e.has_exception        = 1'b0;
         e.old_phy_reg_id_valid = 1'b1;
         e.old_phy_reg_id       = PW'(10 + i);
         rob_mem[idx(i)] = e;
      end
   endtask

   task automatic evolve();
      int n;
      for (int i = 0; i < cnt; i++) begin
         if ($urandom_range(0, 99) < 35) rob_mem[idx(i)].finish = 1'b1;
      end
      n = $urandom_range(0, 3);
      for (int i = 0; i < n && cnt < RSZ; i++) begin
         rob_mem[idx(cnt)] = rnd_item();
         cnt++;
      end
   endtask

   // One clock of stimulus; the expected response goes to the scoreboard.
   task automatic cycle();
      exp_t      x, y;
      int        k, lim;
      rob_item_t h;
      @(posedge clk);
      #1;
      if (rand_en && pend.size() == 0) evolve();
      drive();
      if (pend.size() > 0) begin
         x = pend.pop_front();
         expq.push_back(x);
         if (x.fl) cnt = 0;
      end else if (cnt > 0 && rob_mem[head].finish
                   && rob_mem[head].has_exception) begin
         x = base();
         x.rv  = prv;
         x.rel = prid;
         expq.push_back(x);
         prv  = '0;
         prid = '0;
         for (k = 0; k < cnt; k++) begin
            y = base();
            y.walk   = 1'b1;
            y.fid    = idx(cnt - 1 - k);
            h        = rob_mem[y.fid];
            y.rs_v   = h.old_phy_reg_id_valid;
            y.rs_new = h.new_phy_reg_id;
            y.rs_old = h.old_phy_reg_id;
            pend.push_back(y);
         end
         y = base();
         h = rob_mem[head];
         y.fl  = 1'b1;
         y.pc  = h.pc;
         y.val = h.exception_value;
         y.eid = h.exception_id;
         pend.push_back(y);
      end else begin
         x = base();
         x.rv  = prv;
         x.rel = prid;
         lim = (cnt < CW) ? cnt : CW;
         k = 0;
         while (k < lim && rob_mem[idx(k)].finish
                && !rob_mem[idx(k)].has_exception) k++;
         for (int i = 0; i < CW; i++) begin
            x.pop[i] = (i < k);
            prv[i]   = (i < k) && rob_mem[idx(i)].old_phy_reg_id_valid;
            prid[i]  = rob_mem[idx(i)].old_phy_reg_id;
         end
         expq.push_back(x);
         head  = head + RW'(k);
         cnt   = cnt - k;
         total = total + 64'(k);
      end
   endtask

   task automatic zero_checks();
      chk("rst_pop", 64'(pop), 64'd0);
      chk("rst_retire_id", 64'(rid), 64'd0);
      chk("rst_release_valid", 64'(rel_v), 64'd0);
      chk("rst_release_id", 64'(rel_id), 64'd0);
      chk("rst_restore_valid", 64'(rs_v), 64'd0);
      chk("rst_restore_new", 64'(rs_new), 64'd0);
      chk("rst_restore_old", 64'(rs_old), 64'd0);
      chk("rst_flush_id", 64'(fid), 64'd0);
      chk("rst_rob_flush", 64'(rflush), 64'd0);
      chk("rst_exc_valid", 64'(exc_v), 64'd0);
      chk("rst_exc_pc", 64'(exc_pc), 64'd0);
      chk("rst_exc_value", 64'(exc_val), 64'd0);
      chk("rst_exc_id", 64'(exc_id), 64'd0);
      chk("rst_count", 64'(rcount), 64'd0);
   endtask

   task automatic clear_model();
      pend.delete();
      cnt   = 0;
      total = '0;
      prv   = '0;
      prid  = '0;
   endtask

   // Reset asserted mid-cycle with a retire-ready ROB on the inputs.
   task automatic async_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      load(5'd0, 4);
      drive();
      #1;
      zero_checks();
      clear_model();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin : mon
      exp_t x;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            x = expq.pop_front();
            chk("pop", 64'(pop), 64'(x.pop));
            chk("retire_id", 64'(rid), 64'(x.rid));
            chk("release_valid", 64'(rel_v), 64'(x.rv));
            for (int i = 0; i < CW; i++) begin
               if (x.rv[i]) chk("release_id", 64'(rel_id[i]), 64'(x.rel[i]));
            end
            chk("restore_valid", 64'(rs_v), 64'(x.rs_v));
            chk("rob_flush", 64'(rflush), 64'(x.fl));
            chk("exc_valid", 64'(exc_v), 64'(x.fl));
            chk("retired_count", rcount, x.cnt);
            if (x.walk) begin
               chk("flush_id", 64'(fid), 64'(x.fid));
               chk("restore_new", 64'(rs_new), 64'(x.rs_new));
               chk("restore_old", 64'(rs_old), 64'(x.rs_old));
            end
            if (x.fl) begin
               chk("exc_pc", 64'(exc_pc), 64'(x.pc));
               chk("exc_id", 64'(exc_id), 64'(x.eid));
               chk("exc_value", 64'(exc_val), 64'(x.val));
            end
         end
      end
   end

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      rand_en = 1'b0;
      head    = '0;
      for (int i = 0; i < RSZ; i++) rob_mem[i] = '0;
      clear_model();
      rst = 1'b1;
      drive();
      #1 rst = 1'b0;
      #2 zero_checks();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Full retire across the index wrap.
      load(5'd30, 4);
      cycle();
      cycle();

      // Unfinished slot 2 cuts the prefix; slot 3 waits.
      load(5'd3, 4);
      rob_mem[idx(2)].finish = 1'b0;
      cycle();
      cycle();
      rob_mem[head].finish = 1'b1;
      cycle();
      cycle();

      // Head exception with eight entries: walk 7..0 then trap.
      load(5'd0, 8);
      rob_mem[0].has_exception   = 1'b1;
      rob_mem[0].pc              = 32'h8000_0010;
      rob_mem[0].exception_value = 32'h0000_1001;
      rob_mem[0].exception_id    = EXC_ILLEGAL;
      for (int i = 1; i < 8; i++) begin
         rob_mem[i].old_phy_reg_id_valid = 1'(i % 2);
         rob_mem[i].finish = 1'($urandom_range(0, 1));
      end
      cycle();
      while (pend.size() > 0) cycle();
      cycle();

      // Exception in slot 2 retires slots 0-1 first.
      load(5'd10, 5);
      rob_mem[idx(2)].has_exception = 1'b1;
      cycle();
      cycle();
      while (pend.size() > 0) cycle();
      cycle();

      // Reset during a walk returns to idle without a trap pulse.
      load(5'd20, 6);
      rob_mem[head].has_exception = 1'b1;
      cycle();
      cycle();
      cycle();
      async_reset();
      load(5'd5, 2);
      cycle();
      cycle();
      cycle();

      // Randomized traffic.
      rand_en = 1'b1;
      repeat (1500) cycle();
      rand_en = 1'b0;
      for (int i = 0; i < 40 && pend.size() > 0; i++) cycle();
      cycle();
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 64'(expq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
